// File: rtl/lock_servo_driver.sv
// Servo latch driver: 50 Hz PWM whose width follows a four-state move machine,
// driven by edges of the lock_open command level, with timed settle and auto-relock.
module lock_servo_driver #(
    parameter int PERIOD_CLKS        = 1_000_000,
    parameter int PULSE_CLOSED_CLKS  = 50_000,
    parameter int PULSE_OPEN_CLKS    = 100_000,
    parameter int SETTLE_FRAMES      = 25,
    parameter int AUTO_RELOCK_FRAMES = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic lock_open,
    output logic servo_pwm,
    output logic is_open,
    output logic busy,
    output logic relock_evt
);
    localparam int FW = $clog2(PERIOD_CLKS) + 1;
    localparam int SW = $clog2(SETTLE_FRAMES) + 1;
    localparam int RW = $clog2(AUTO_RELOCK_FRAMES) + 1;
    localparam logic [FW-1:0] FCNT_LAST   = FW'(PERIOD_CLKS - 1);
    localparam logic [FW-1:0] PW_OPEN     = FW'(PULSE_OPEN_CLKS);
    localparam logic [FW-1:0] PW_CLOSED   = FW'(PULSE_CLOSED_CLKS);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_FRAMES - 1);
    localparam logic [RW-1:0] RELOCK_LAST = RW'(AUTO_RELOCK_FRAMES - 1);
    localparam bit            RELOCK_EN   = (AUTO_RELOCK_FRAMES != 0);

    typedef enum logic [1:0] {CLOSED, OPENING, OPEN, CLOSING} state_t;

    state_t        state;
    logic [FW-1:0] fcnt;
    logic [FW-1:0] pw;
    logic [SW-1:0] settle_cnt;
    logic [RW-1:0] relock_cnt;
    logic          cmd_q;
    logic          open_req;
    logic          close_req;
    logic          pend_valid;
    logic          pend_open;
    logic          frame_tick;
    logic          settle_done;
    logic          relock_due;
    logic          nxt_pend_valid;
    logic          nxt_pend_open;

    // Counters stop one short of their limit: the limit is reached on the tick that moves state.
    always_comb begin
        frame_tick     = (fcnt == FCNT_LAST);
        settle_done    = frame_tick && (settle_cnt == SETTLE_LAST);
        relock_due     = RELOCK_EN && frame_tick && (relock_cnt == RELOCK_LAST);
        nxt_pend_valid = pend_valid | open_req | close_req;
        nxt_pend_open  = open_req ? 1'b1 : (close_req ? 1'b0 : pend_open);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt      <= '0;
            pw        <= PW_CLOSED;
            servo_pwm <= 1'b0;
        end else begin
            fcnt <= frame_tick ? '0 : fcnt + 1'b1;
            if (fcnt == '0)
                pw <= (state == OPENING || state == OPEN) ? PW_OPEN : PW_CLOSED;
            servo_pwm <= (fcnt < pw);
        end
    end

    // Requests are registered once more so the FSM sees a clean one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q     <= 1'b0;
            open_req  <= 1'b0;
            close_req <= 1'b0;
        end else begin
            cmd_q     <= lock_open;
            open_req  <= lock_open & ~cmd_q;
            close_req <= ~lock_open & cmd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLOSED;
            settle_cnt <= '0;
            relock_cnt <= '0;
            pend_valid <= 1'b0;
            pend_open  <= 1'b0;
            is_open    <= 1'b0;
            busy       <= 1'b0;
            relock_evt <= 1'b0;
        end else begin
            relock_evt <= 1'b0;
            case (state)
                CLOSED: begin
                    if (open_req || pend_valid) begin
                        state      <= OPENING;
                        busy       <= 1'b1;
                        settle_cnt <= '0;
                        relock_cnt <= '0;
                        pend_valid <= 1'b0;
                    end
                end
                OPENING: begin
                    if (settle_done) begin
                        state      <= OPEN;
                        is_open    <= 1'b1;
                        busy       <= 1'b0;
                        settle_cnt <= '0;
                        relock_cnt <= '0;
                        pend_valid <= nxt_pend_valid & ~nxt_pend_open;
                    end else begin
                        if (frame_tick)
                            settle_cnt <= settle_cnt + 1'b1;
                        pend_valid <= nxt_pend_valid;
                        pend_open  <= nxt_pend_open;
                    end
                end
                OPEN: begin
                    // A pending entry here can only be a close carried over from OPENING.
                    if (close_req || pend_valid || relock_due) begin
                        state      <= CLOSING;
                        is_open    <= 1'b0;
                        busy       <= 1'b1;
                        settle_cnt <= '0;
                        relock_cnt <= '0;
                        pend_valid <= 1'b0;
                        relock_evt <= relock_due && !close_req && !pend_valid;
                    end else if (RELOCK_EN && frame_tick) begin
                        relock_cnt <= relock_cnt + 1'b1;
                    end
                end
                CLOSING: begin
                    if (settle_done) begin
                        state      <= CLOSED;
                        busy       <= 1'b0;
                        settle_cnt <= '0;
                        relock_cnt <= '0;
                        pend_valid <= nxt_pend_valid & nxt_pend_open;
                    end else begin
                        if (frame_tick)
                            settle_cnt <= settle_cnt + 1'b1;
                        pend_valid <= nxt_pend_valid;
                        pend_open  <= nxt_pend_open;
                    end
                end
                default: begin
                    state   <= CLOSED;
                    is_open <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule
